// File: rtl/led_fade.sv
// PWM fade stage for the chaser LEDs: each channel's duty ramps toward full-on or
// full-off one step per prescaler tick, and a free-running PWM counter modulates the drive.

module led_fade_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                on,
    input  logic                fade_en,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                drive,
    output logic                diff
);
    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] tgt;

    assign tgt  = on ? MAX : '0;
    assign diff = (duty != tgt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty  <= '0;
            drive <= 1'b0;
        end else begin
            if (!fade_en) begin
                duty <= tgt;
            end else if (tick) begin
                // saturating walk toward the target; reversal just changes direction
                if (on && duty != MAX)
                    duty <= duty + PWM_BITS'(1);
                else if (!on && duty != '0)
                    duty <= duty - PWM_BITS'(1);
            end
            // full scale forced high so the pwm_cnt==MAX slot does not drop out
            drive <= (duty == MAX) | (pwm_cnt < duty);
        end
    end
endmodule

module led_fade #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 195_312
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_in,
    input  logic       fade_en,
    output logic [3:0] led_out,
    output logic       busy
);
    localparam int NUM_LANES = 4;
    localparam int SW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    logic [NUM_LANES-1:0] led_q;
    logic [NUM_LANES-1:0] diff;
    logic [SW-1:0]        step_cnt;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 tick;

    assign tick = (step_cnt == STEP_LAST);
    assign busy = |diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q    <= '0;
            step_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            led_q    <= led_in;
            step_cnt <= tick ? '0 : step_cnt + SW'(1);
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        led_fade_lane #(
            .PWM_BITS(PWM_BITS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .on     (led_q[i]),
            .fade_en(fade_en),
            .tick   (tick),
            .pwm_cnt(pwm_cnt),
            .drive  (led_out[i]),
            .diff   (diff[i])
        );
    end
endmodule

// File: tb/tb_led_fade.sv
// Scoreboard bench for led_fade at PWM_BITS=3, STEP_DIV=4; expected outputs are keyed
// to the number of clock edges since reset release.

module tb_led_fade;
    logic       clk;
    logic       rst;
    logic [3:0] led_in;
    logic       fade_en;
    logic [3:0] led_out;
    logic       busy;

    led_fade #(.PWM_BITS(3), .STEP_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in),
        .fade_en(fade_en),
        .led_out(led_out),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        int         kind;   // 0: led_out/busy snapshot, 1: high count over last 8 cycles
        logic [3:0] led;
        logic       bsy;
        int         ch;
        int         cnt;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] hist [4];
    event       sample_ev;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    task automatic check_front();
        exp_t e;
        int   got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s missed check at cyc %0d (now %0d)", e.name, e.cyc, cyc);
            end else if (e.kind == 0) begin
                if (led_out !== e.led || busy !== e.bsy) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d led_out=%b busy=%b required led_out=%b busy=%b",
                             e.name, cyc, led_out, busy, e.led, e.bsy);
                end
            end else begin
                got = $countones(hist[e.ch]);
                if (got != e.cnt) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d ch%0d high=%0d of 8, required %0d",
                             e.name, cyc, e.ch, got, e.cnt);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) hist[i] = {hist[i][6:0], led_out[i]};
            check_front();
        end
    end

    initial forever begin
        @(sample_ev);
        check_front();
    end

    task automatic exp_out(input int c, input logic [3:0] l, input logic b, input string n);
        exp_t e;
        e.cyc = c; e.kind = 0; e.led = l; e.bsy = b; e.ch = 0; e.cnt = 0; e.name = n;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input int c, input int ch, input int n, input string nm);
        exp_t e;
        e.cyc = c; e.kind = 1; e.led = '0; e.bsy = 1'b0; e.ch = ch; e.cnt = n; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic go_to(input int n);
        int k = 0;
        while (cyc != n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (cyc != n) begin
            n_tests++;
            n_fail++;
            $display("FAIL go_to cyc=%0d required %0d", cyc, n);
        end
    endtask

    task automatic drain(input string n);
        int k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout, %0d checks pending, required 0", n, sb.size());
            sb.delete();
        end
    endtask

    // Reset with hold_led applied (must not leak through), then release with run_led.
    task automatic start(input logic [3:0] hold_led, input logic [3:0] run_led, input logic fe);
        @(negedge clk);
        rst = 1'b1;
        led_in = hold_led;
        fade_en = fe;
        #1;
        exp_out(0, 4'b0000, 1'b0, "rst_async");
        ->sample_ev;
        repeat (3) @(negedge clk);
        exp_out(0, 4'b0000, 1'b0, "rst_hold");
        @(negedge clk);
        led_in = run_led;
        rst = 1'b0;
    endtask

    logic [3:0] walk [4];

    initial begin
        rst = 1'b1;
        led_in = 4'b0000;
        fade_en = 1'b1;
        walk[0] = 4'b1000; walk[1] = 4'b0100; walk[2] = 4'b0010; walk[3] = 4'b0001;
        repeat (2) @(negedge clk);

        // fade in on channel 0
        start(4'b1111, 4'b0001, 1'b1);
        exp_out(1,  4'b0000, 1'b1, "fi_busy_rise");
        exp_out(4,  4'b0000, 1'b1, "fi_d0");
        exp_out(5,  4'b0000, 1'b1, "fi_d1_low");
        exp_out(9,  4'b0001, 1'b1, "fi_d2_hi0");
        exp_out(10, 4'b0001, 1'b1, "fi_d2_hi1");
        exp_out(11, 4'b0000, 1'b1, "fi_d2_low");
        exp_out(27, 4'b0001, 1'b1, "fi_d6");
        exp_out(28, 4'b0001, 1'b0, "fi_busy_fall");
        for (int c = 29; c <= 44; c++) exp_out(c, 4'b0001, 1'b0, "fi_full_on");
        drain("fade_in");

        // PWM shape: hold duty oscillating 3/2 so the visible pattern is duty 3
        start(4'b1111, 4'b0000, 1'b1);
        exp_out(17, 4'b0001, 1'b1, "pw_hi_p0");
        exp_out(19, 4'b0001, 1'b1, "pw_hi_p2");
        exp_out(20, 4'b0000, 1'b1, "pw_lo_p3");
        exp_out(22, 4'b0000, 1'b1, "pw_lo_p5");
        exp_cnt(24, 0, 3, "pw_win1");
        exp_out(25, 4'b0001, 1'b1, "pw_hi_p0b");
        exp_out(28, 4'b0000, 1'b1, "pw_lo_p3b");
        exp_cnt(32, 0, 3, "pw_win2");
        exp_cnt(32, 1, 0, "pw_ch1_off");
        exp_cnt(40, 0, 3, "pw_win3");
        exp_out(43, 4'b0000, 1'b1, "pw_tail_busy");
        exp_out(44, 4'b0000, 1'b0, "pw_tail_idle");
        go_to(3);  led_in = 4'b0001;
        go_to(16); led_in = 4'b0000;
        go_to(20); led_in = 4'b0001;
        go_to(24); led_in = 4'b0000;
        go_to(28); led_in = 4'b0001;
        go_to(32); led_in = 4'b0000;
        drain("pwm_shape");

        // reversal on channel 1 from duty 4, must saturate at 0
        start(4'b1111, 4'b0010, 1'b1);
        exp_out(17, 4'b0010, 1'b1, "rv_d4_a");
        exp_out(20, 4'b0010, 1'b1, "rv_d4_hold");
        exp_out(21, 4'b0000, 1'b1, "rv_d3");
        exp_out(25, 4'b0010, 1'b1, "rv_d2_a");
        exp_out(26, 4'b0010, 1'b1, "rv_d2_b");
        exp_out(27, 4'b0000, 1'b1, "rv_d2_c");
        exp_out(31, 4'b0000, 1'b1, "rv_d1_busy");
        exp_out(32, 4'b0000, 1'b0, "rv_d0_idle");
        for (int c = 33; c <= 48; c++) exp_out(c, 4'b0000, 1'b0, "rv_no_wrap");
        go_to(16); led_in = 4'b0000;
        drain("reversal");

        // bypass: hard switching, 3-cycle latency, single-cycle busy
        start(4'b1111, 4'b1000, 1'b0);
        exp_out(1, 4'b0000, 1'b1, "by_busy0");
        exp_out(2, 4'b0000, 1'b0, "by_idle0");
        for (int c = 3; c <= 9; c++) exp_out(c, walk[0], 1'b0, "by_step0");
        for (int j = 1; j < 4; j++) begin
            exp_out(10*j + 1, walk[j-1], 1'b1, "by_busy");
            exp_out(10*j + 2, walk[j-1], 1'b0, "by_idle");
            for (int c = 10*j + 3; c <= 10*j + 9; c++) exp_out(c, walk[j], 1'b0, "by_step");
        end
        go_to(10); led_in = walk[1];
        go_to(20); led_in = walk[2];
        go_to(30); led_in = walk[3];
        drain("bypass");

        // async reset at duty 5, ramp restarts from 0
        start(4'b1111, 4'b0001, 1'b1);
        exp_out(9,  4'b0001, 1'b1, "ar_pre_d2");
        exp_out(21, 4'b0001, 1'b1, "ar_pre_d5");
        drain("ar_pre");
        #2;
        rst = 1'b1;
        #1;
        exp_out(0, 4'b0000, 1'b0, "ar_async");
        ->sample_ev;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_out(1,  4'b0000, 1'b1, "ar_busy_rise");
        exp_out(5,  4'b0000, 1'b1, "ar_d1_low");
        exp_out(9,  4'b0001, 1'b1, "ar_d2_hi");
        exp_out(11, 4'b0000, 1'b1, "ar_d2_low");
        drain("ar_post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired, %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end
endmodule
